// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//   Multi-LED animation driver. A prescaler produces one advance per
//   PRESC_DIV clocks. On each advance the LED pattern either restarts at the
//   entry value of a newly selected mode or steps to its next value. The
//   pattern is then gated by a global PWM dimmer before driving the pins.
//
// Ports
//   clk      : board clock, rising-edge logic
//   rstn     : asynchronous active-low reset
//   mode     : 0 STATIC, 1 BLINK, 2 RUN, 3 BOUNCE (sampled on step)
//   pattern  : STATIC source pattern (sampled on step)
//   duty     : PWM brightness, all ones = fully on (sampled every cycle)
//   leds     : registered LED drive, active-high
//   step     : registered one-cycle pulse per pattern advance
// -----------------------------------------------------------------------------
module led_sequencer #(
  parameter int N_LEDS    = 5,
  parameter int PRESC_DIV = 1_200_000,
  parameter int PWM_BITS  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          mode,
  input  logic [N_LEDS-1:0]   pattern,
  input  logic [PWM_BITS-1:0] duty,
  output logic [N_LEDS-1:0]   leds,
  output logic                step
);

  localparam int                CNT_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESC_DIV - 1);
  localparam logic [N_LEDS-1:0] PAT_ONE  = N_LEDS'(1);

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_BLINK  = 2'd1,
    M_RUN    = 2'd2,
    M_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic [CNT_W-1:0]    r_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  mode_e               r_mode_q;
  logic [N_LEDS-1:0]   r_pat;
  dir_e                r_dir;
  logic [N_LEDS-1:0]   r_leds;
  logic                r_step;

  logic                w_adv;
  logic                w_pwm_on;
  logic [N_LEDS-1:0]   w_shl;
  logic [N_LEDS-1:0]   w_shr;
  logic [N_LEDS-1:0]   w_pat_nxt;
  dir_e                w_dir_nxt;

  assign w_adv    = (r_cnt == CNT_LAST);
  // Full-scale duty bypasses the compare so it really is 100 % on.
  assign w_pwm_on = (duty == '1) || (r_pwm_cnt < duty);
  assign w_shl    = r_pat << 1;
  assign w_shr    = r_pat >> 1;

  // Next pattern / direction: a mode change restarts at the mode's entry
  // value, otherwise the registered mode decides how the pattern moves.
  always_comb begin
    w_pat_nxt = r_pat;
    w_dir_nxt = r_dir;
    if (w_adv) begin
      if (mode != r_mode_q) begin
        w_dir_nxt = DIR_LEFT;
        case (mode_e'(mode))
          M_STATIC: w_pat_nxt = pattern;
          M_BLINK:  w_pat_nxt = '1;
          M_RUN:    w_pat_nxt = PAT_ONE;
          M_BOUNCE: w_pat_nxt = PAT_ONE;
          default:  w_pat_nxt = r_pat;
        endcase
      end else begin
        case (r_mode_q)
          M_STATIC: w_pat_nxt = pattern;
          M_BLINK:  w_pat_nxt = ~r_pat;
          // Rotate left; for a single LED this degenerates to identity.
          M_RUN:    w_pat_nxt = w_shl | (r_pat >> (N_LEDS - 1));
          M_BOUNCE: begin
            if (N_LEDS == 1) begin
              w_pat_nxt = r_pat;
            end else if (r_dir == DIR_LEFT) begin
              w_pat_nxt = w_shl;
              if (w_shl[N_LEDS-1]) w_dir_nxt = DIR_RIGHT;
            end else begin
              w_pat_nxt = w_shr;
              if (w_shr[0]) w_dir_nxt = DIR_LEFT;
            end
          end
          default:  w_pat_nxt = r_pat;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_pwm_cnt <= '0;
      r_mode_q  <= M_STATIC;
      r_pat     <= '0;
      r_dir     <= DIR_LEFT;
      r_leds    <= '0;
      r_step    <= 1'b0;
    end else begin
      r_cnt     <= w_adv ? '0 : r_cnt + CNT_W'(1);
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (w_adv) r_mode_q <= mode_e'(mode);
      r_pat     <= w_pat_nxt;
      r_dir     <= w_dir_nxt;
      r_leds    <= r_pat & {N_LEDS{w_pwm_on}};
      r_step    <= w_adv;
    end
  end

  assign leds = r_leds;
  assign step = r_step;

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  localparam int N_LEDS    = 5;
  localparam int PRESC_DIV = 4;
  localparam int PWM_BITS  = 2;
  localparam int N_VEC     = 22;

  logic                clk = 1'b0;
  logic                rstn = 1'b1;
  logic [1:0]          mode = 2'd2;
  logic [N_LEDS-1:0]   pattern = '0;
  logic [PWM_BITS-1:0] duty = 2'd3;
  logic [N_LEDS-1:0]   leds;
  logic                step;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]        mode;
    logic [N_LEDS-1:0] pattern;
    logic [1:0]        duty;
    logic [N_LEDS-1:0] exp_leds;
  } vec_t;

  vec_t vecs [N_VEC];

  led_sequencer #(
    .N_LEDS   (N_LEDS),
    .PRESC_DIV(PRESC_DIV),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .mode   (mode),
    .pattern(pattern),
    .duty   (duty),
    .leds   (leds),
    .step   (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act[N_LEDS-1:0], exp[N_LEDS-1:0]);
    end
  endtask

  // Waits for the next step pulse (bounded), then one more cycle so leds
  // shows the freshly advanced pattern.
  task automatic wait_step(input string name);
    bit found = 0;
    for (int i = 0; i < 3 * PRESC_DIV; i++) begin
      @(negedge clk);
      if (step) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: step timeout, got none expected pulse within %0d cycles",
               name, 3 * PRESC_DIV);
    end
    @(negedge clk);
    check({name, "_step_width"}, {31'd0, step}, 32'd0);
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [N_LEDS-1:0] p,
                              input logic [N_LEDS-1:0] e);
    vec_t v;
    v.mode = m; v.pattern = p; v.duty = 2'd3; v.exp_leds = e;
    return v;
  endfunction

  initial begin
    int on_cnt;
    int bad_cnt;
    logic [1:0] duties [4];
    int         exp_on [4];

    // RUN from reset, wrap, then a few more steps
    vecs[0]  = mk(2'd2, 5'b00000, 5'b00001);
    vecs[1]  = mk(2'd2, 5'b00000, 5'b00010);
    vecs[2]  = mk(2'd2, 5'b00000, 5'b00100);
    vecs[3]  = mk(2'd2, 5'b00000, 5'b01000);
    vecs[4]  = mk(2'd2, 5'b00000, 5'b10000);
    vecs[5]  = mk(2'd2, 5'b00000, 5'b00001);
    vecs[6]  = mk(2'd2, 5'b00000, 5'b00010);
    vecs[7]  = mk(2'd2, 5'b00000, 5'b00100);
    // switch to BOUNCE while RUN sits at 00100: restart at 00001
    vecs[8]  = mk(2'd3, 5'b00000, 5'b00001);
    vecs[9]  = mk(2'd3, 5'b00000, 5'b00010);
    vecs[10] = mk(2'd3, 5'b00000, 5'b00100);
    vecs[11] = mk(2'd3, 5'b00000, 5'b01000);
    vecs[12] = mk(2'd3, 5'b00000, 5'b10000);
    vecs[13] = mk(2'd3, 5'b00000, 5'b01000);
    vecs[14] = mk(2'd3, 5'b00000, 5'b00100);
    vecs[15] = mk(2'd3, 5'b00000, 5'b00010);
    vecs[16] = mk(2'd3, 5'b00000, 5'b00001);
    vecs[17] = mk(2'd3, 5'b00000, 5'b00010);
    // BLINK then STATIC
    vecs[18] = mk(2'd1, 5'b00000, 5'b11111);
    vecs[19] = mk(2'd1, 5'b00000, 5'b00000);
    vecs[20] = mk(2'd1, 5'b00000, 5'b11111);
    vecs[21] = mk(2'd0, 5'b10110, 5'b10110);

    // Reset state
    #3 rstn = 1'b0;
    #1;
    check("reset_leds", {27'd0, leds}, 32'd0);
    check("reset_step", {31'd0, step}, 32'd0);
    repeat (3) @(negedge clk);
    check("reset_hold_leds", {27'd0, leds}, 32'd0);
    rstn = 1'b1;

    // Table-driven sequences
    for (int i = 0; i < N_VEC; i++) begin
      mode    = vecs[i].mode;
      pattern = vecs[i].pattern;
      duty    = vecs[i].duty;
      wait_step($sformatf("vec%0d", i));
      check($sformatf("vec%0d_leds", i), {27'd0, leds}, {27'd0, vecs[i].exp_leds});
    end

    // pattern change between steps only shows at the following step
    pattern = 5'b01001;
    @(negedge clk);
    check("pat_hold_a", {27'd0, leds}, {27'd0, 5'b10110});
    @(negedge clk);
    check("pat_hold_b", {27'd0, leds}, {27'd0, 5'b10110});
    wait_step("pat_change");
    check("pat_change_leds", {27'd0, leds}, {27'd0, 5'b01001});

    // PWM dimming on a static 10101 pattern
    pattern = 5'b10101;
    wait_step("pwm_load");
    check("pwm_load_leds", {27'd0, leds}, {27'd0, 5'b10101});
    duties[0] = 2'd1; exp_on[0] = 2;
    duties[1] = 2'd2; exp_on[1] = 4;
    duties[2] = 2'd0; exp_on[2] = 0;
    duties[3] = 2'd3; exp_on[3] = 8;
    for (int d = 0; d < 4; d++) begin
      duty    = duties[d];
      on_cnt  = 0;
      bad_cnt = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (leds == 5'b10101) on_cnt++;
        else if (leds != 5'b00000) bad_cnt++;
      end
      check($sformatf("pwm_duty%0d_on", duties[d]), on_cnt, exp_on[d]);
      check($sformatf("pwm_duty%0d_bad", duties[d]), bad_cnt, 0);
    end

    // Asynchronous reset mid-run, then step cadence after release
    @(negedge clk);
    check("pre_reset_leds", {27'd0, leds}, {27'd0, 5'b10101});
    #2 rstn = 1'b0;
    #1;
    check("async_reset_leds", {27'd0, leds}, 32'd0);
    check("async_reset_step", {31'd0, step}, 32'd0);
    repeat (2) @(negedge clk);
    check("async_hold_leds", {27'd0, leds}, 32'd0);
    rstn = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("rel_edge%0d_step", e), {31'd0, step}, (e % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rel_edge%0d_leds", e), {27'd0, leds},
            (e >= 5) ? {27'd0, 5'b10101} : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
